// File: rtl/bcd_countdown_ctrl.sv
// Multi-digit BCD down-counter sequencer: load, prescaled decrement, pause/resume, clear, done.
// Optional macro BCD_CNT_AUTORELOAD_EN: reload the last start value on the terminal tick instead of stopping.
module bcd_countdown_ctrl #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] cnt,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state
);

  // state | meaning
  // IDLE  | cleared, count zero, waiting for start
  // RUN   | prescaler counting, cnt decrements on each tick
  // PAUSE | prescaler and cnt frozen until the next pause pulse
  // DONE  | count reached zero, waiting for start or clear

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t        st_q, st_nx;
  logic [W-1:0]  cnt_q, cnt_nx;
  logic [PW-1:0] pre_q, pre_nx;
  logic [W-1:0]  load_sat, cnt_dec;
  logic          tick;

  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // Ripple borrow from the least significant digit; only used with cnt != 0.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign load_sat = bcd_sat(load_val);
  assign cnt_dec  = bcd_dec(cnt_q);
  assign tick     = (pre_q == PW'(PRESCALE - 1));

`ifdef BCD_CNT_AUTORELOAD_EN
  logic [W-1:0] rld_q, rld_nx;
  logic         pulse_q, pulse_nx;
`endif

  always_comb begin
    st_nx  = st_q;
    cnt_nx = cnt_q;
    pre_nx = pre_q;
`ifdef BCD_CNT_AUTORELOAD_EN
    rld_nx   = rld_q;
    pulse_nx = 1'b0;
`endif
    if (clear) begin
      st_nx  = IDLE;
      cnt_nx = '0;
      pre_nx = '0;
    end else if (start) begin
      st_nx  = RUN;
      cnt_nx = load_sat;
      pre_nx = '0;
`ifdef BCD_CNT_AUTORELOAD_EN
      rld_nx = load_sat;
`endif
    end else begin
      case (st_q)
        RUN: begin
          if (cnt_q == '0) begin
            st_nx = DONE;
          end else if (tick) begin
            pre_nx = '0;
            if (cnt_dec == '0) begin
`ifdef BCD_CNT_AUTORELOAD_EN
              cnt_nx   = rld_q;
              pulse_nx = 1'b1;
              if (pause) st_nx = PAUSE;
`else
              cnt_nx = '0;
              st_nx  = DONE;
`endif
            end else begin
              cnt_nx = cnt_dec;
              if (pause) st_nx = PAUSE;
            end
          end else if (pause) begin
            st_nx = PAUSE;
          end else begin
            pre_nx = pre_q + PW'(1);
          end
        end
        PAUSE: if (pause) st_nx = RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      st_q  <= st_nx;
      cnt_q <= cnt_nx;
      pre_q <= pre_nx;
    end
  end

`ifdef BCD_CNT_AUTORELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rld_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      rld_q   <= rld_nx;
      pulse_q <= pulse_nx;
    end
  end
  assign done = (st_q == DONE) || pulse_q;
`else
  assign done = (st_q == DONE);
`endif

  assign cnt   = cnt_q;
  assign busy  = (st_q == RUN) || (st_q == PAUSE);
  assign state = st_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed bench for bcd_countdown_ctrl (DIGITS=2, PRESCALE=4); autoreload checks when BCD_CNT_AUTORELOAD_EN is defined.
module tb_bcd_countdown_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, pause, clear;
  logic [7:0] load_val;
  logic [7:0] cnt;
  logic       busy, done;
  logic [1:0] state;
  int         n_cmp = 0;
  int         n_bad = 0;

  bcd_countdown_ctrl #(.DIGITS(2), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .load_val(load_val), .cnt(cnt), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] v);
    load_val = v;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    step(1);
    pause = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load_val = 8'h00;
    #3;
    chk("rst_cnt", cnt, 8'h00);
    chk("rst_state", state, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    #9 rst = 1'b0;
    step(1);

    // borrow across digits
    pulse_start(8'h10);
    chk("brw_load", cnt, 8'h10);
    chk("brw_busy", busy, 1'b1);
    chk("brw_state", state, 2'd1);
    step(3);
    chk("brw_hold", cnt, 8'h10);
    step(1);
    chk("brw_09", cnt, 8'h09);
    step(4);
    chk("brw_08", cnt, 8'h08);
    chk("brw_busy2", busy, 1'b1);

`ifndef BCD_CNT_AUTORELOAD_EN
    // terminal
    pulse_start(8'h02);
    chk("trm_02", cnt, 8'h02);
    step(4);
    chk("trm_01", cnt, 8'h01);
    chk("trm_done0", done, 1'b0);
    step(4);
    chk("trm_00", cnt, 8'h00);
    chk("trm_done", done, 1'b1);
    chk("trm_state", state, 2'd3);
    chk("trm_busy", busy, 1'b0);
    pulse_pause();
    step(19);
    chk("trm_hold_cnt", cnt, 8'h00);
    chk("trm_hold_state", state, 2'd3);
    chk("trm_hold_done", done, 1'b1);
`endif

    // async reset mid-count
    pulse_start(8'h07);
    step(2);
    chk("mid_pre", cnt, 8'h07);
    #2 rst = 1'b1;
    #1;
    chk("mid_cnt", cnt, 8'h00);
    chk("mid_state", state, 2'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    #2 rst = 1'b0;
    step(1);

    // pause / resume with prescaler held at 2
    pulse_start(8'h05);
    step(2);
    pulse_pause();
    chk("pau_state", state, 2'd2);
    chk("pau_busy", busy, 1'b1);
    step(10);
    chk("pau_hold", cnt, 8'h05);
    chk("pau_state2", state, 2'd2);
    pulse_pause();
    chk("res_state", state, 2'd1);
    chk("res_cnt0", cnt, 8'h05);
    step(1);
    chk("res_cnt1", cnt, 8'h05);
    step(1);
    chk("res_04", cnt, 8'h04);

    // clear beats start
    start = 1'b1; clear = 1'b1; load_val = 8'h55;
    step(1);
    start = 1'b0; clear = 1'b0;
    chk("pri_state", state, 2'd0);
    chk("pri_cnt", cnt, 8'h00);
    chk("pri_busy", busy, 1'b0);

    // saturation
    pulse_start(8'hAF);
    chk("sat_cnt", cnt, 8'h99);
    step(4);
    chk("sat_98", cnt, 8'h98);

    // restart during PAUSE
    pulse_start(8'h42);
    pulse_pause();
    chk("rsp_paused", state, 2'd2);
    pulse_start(8'h30);
    chk("rsp_cnt", cnt, 8'h30);
    chk("rsp_state", state, 2'd1);
    step(4);
    chk("rsp_29", cnt, 8'h29);

    // pause coincident with a tick
    pulse_start(8'h03);
    step(3);
    pulse_pause();
    chk("ptk_cnt", cnt, 8'h02);
    chk("ptk_state", state, 2'd2);

`ifndef BCD_CNT_AUTORELOAD_EN
    // pause coincident with terminal tick
    pulse_start(8'h01);
    step(3);
    pulse_pause();
    chk("ptm_cnt", cnt, 8'h00);
    chk("ptm_state", state, 2'd3);
`endif

    // zero load: RUN for one edge then DONE, no wrap
    pulse_start(8'h00);
    chk("z_state0", state, 2'd1);
    chk("z_cnt0", cnt, 8'h00);
    step(1);
    chk("z_state1", state, 2'd3);
    chk("z_done", done, 1'b1);
    chk("z_cnt1", cnt, 8'h00);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_state", state, 2'd0);
    chk("clr_done", done, 1'b0);

`ifdef BCD_CNT_AUTORELOAD_EN
    pulse_start(8'h01);
    chk("ar_load", cnt, 8'h01);
    chk("ar_done0", done, 1'b0);
    step(3);
    chk("ar_pre", cnt, 8'h01);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("ar_pulse", done, 1'b1);
      chk("ar_cnt", cnt, 8'h01);
      chk("ar_run", state, 2'd1);
      for (int j = 0; j < 3; j++) begin
        step(1);
        chk("ar_nopulse", done, 1'b0);
        chk("ar_not3", state == 2'd3, 1'b0);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_countdown_ctrl.md
Name: bcd_countdown_ctrl

Overview:
- Sequencing controller for a multi-digit BCD down-counter datapath, held internally as one 4-bit register per digit.
- Loads a BCD start value and decrements it once every PRESCALE clocks.
- Supports pause/resume, clear and restart; flags completion at 0.
- Sits between push-button/debounce logic and seven-segment display drivers in the lab timer designs.

Parameters:
- DIGITS, 2, number of BCD digits; cnt and load_val are 4*DIGITS bits wide.
- PRESCALE, 4, clocks per decrement step; must be >= 2. Prescaler width is $clog2(PRESCALE).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse: load load_val and run.
- pause  input  1  single-cycle pulse: toggle RUN/PAUSE.
- clear  input  1  single-cycle pulse: abort to IDLE and zero the count.
- load_val  input  4*DIGITS  BCD start value; digit i is bits [4i+3:4i].
- cnt  output  4*DIGITS  current BCD count, registered.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high while in DONE.
- state  output  2  encoding IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (async, takes effect immediately): state=IDLE, cnt=0, prescaler=0, busy=0, done=0.
- Input priority within a cycle: clear > start > pause.
- clear, any state: next edge gives IDLE, cnt=0, prescaler=0.
- start, any state, including mid-RUN/PAUSE/DONE:
  - Next edge: cnt=load_val, prescaler=0, state=RUN.
  - Any load_val digit >9 is saturated to 9 on load.
  - If the loaded value is 0, state goes to DONE on the following edge; no decrement occurs.
- RUN:
  - Prescaler increments every clock.
  - When prescaler==PRESCALE-1, a tick occurs: prescaler wraps to 0 and cnt decrements by one in BCD.
  - BCD decrement: the least significant digit 0 becomes 9 with a borrow into the next digit; otherwise digit-1.
  - The first decrement occurs on the PRESCALE-th edge after the start edge.
- Terminal: on the tick where the decremented value equals 0, cnt=0 and state=DONE on that same edge. cnt never wraps below 0 in RUN.
- pause in RUN goes to PAUSE; prescaler and cnt hold.
- pause in PAUSE goes to RUN; the prescaler resumes from its held value.
- pause in IDLE or DONE is ignored.
- pause coincident with a tick: the decrement is applied, then the state goes to PAUSE. If that decrement reaches 0, the state goes to DONE instead.
- DONE: cnt holds 0, done=1. Leaves only on start (to RUN) or clear (to IDLE).
- Outputs busy, done and state are decoded from the state register, so they are registered-equivalent with no combinational path from the inputs.

Optional Feature:
- Macro: BCD_CNT_AUTORELOAD_EN.
- Defined:
  - The value captured at the last start is held in a reload register.
  - On the terminal tick, cnt is reloaded instead of entering DONE, and the state stays RUN.
  - done becomes a one-cycle pulse on that edge.
  - A captured value of 0 still goes to DONE.
- Undefined: behaviour as above and no reload register is synthesised.

Test Plan:
- Reset mid-count: assert rst asynchronously between edges while in RUN with cnt=07 -> cnt=00, state=0, busy=0, done=0 immediately, before the next clock edge.
- Borrow: load_val=8'h10, pulse start -> cnt=10 after the start edge, 09 four edges later, 08 four edges after that; busy=1.
- Terminal: load_val=8'h02, start -> cnt 02,01,00 at 4-clock steps; done=1 and state=3 on the edge cnt reaches 00. It stays 00 for 20 further clocks; pause is ignored.
- Pause/resume: load 05, start, pause at prescaler=2 -> cnt stays 05 for 10 clocks. Pulse pause again -> cnt=04 two edges later.
- Priority and saturation: start and clear in the same cycle -> IDLE, cnt=00. Then load_val=8'hAF, start -> cnt=99. start during PAUSE at cnt=42 with load_val=8'h30 -> cnt=30, RUN.
- BCD_CNT_AUTORELOAD_EN build: load 01, start -> 01 then 00→01 reload on the terminal tick with a one-cycle done pulse, repeating every 4 clocks; state never equals 3.
